tof_echo_detector: RTL and testbench
====================================

# tof_echo_detector

Time-of-flight echo detector sitting directly downstream of the FIR band-pass filter in the ultrasonic receive chain. It consumes the filter's source stream (`ast_source_data` / `ast_source_valid`) and squares each sample to get instantaneous energy. After a blanking window that masks transmitter crosstalk, it searches for the first run of `HOLD` consecutive samples whose energy exceeds a threshold. It then reports the sample index of that run's first sample, counted from the start of the transmit burst.

## Interface
Parameters:
- `DATA_W`, 28, signed width of the FIR output sample.
- `CNT_W`, 16, width of the sample index and `tof_count`.
- `BLANK`, 64, samples ignored after burst start.
- `HOLD`, 3, consecutive above-threshold samples needed to declare an echo (≥1).
- `MAX_SAMPLES`, 3800, search window in samples, counted from burst start; must be less than 2^CNT_W.

Ports:
- `CLK_FAST`  in  1  system clock (70 MHz).
- `RST`  in  1  synchronous, active-high reset.
- `burst_start`  in  1  one-cycle pulse marking the start of the transmit burst.
- `sample_valid`  in  1  FIR `ast_source_valid`.
- `sample_data`  in  DATA_W  FIR `ast_source_data`, two's complement.
- `threshold`  in  2*DATA_W  unsigned energy threshold; sampled at `burst_start`.
- `busy`  out  1  high while in BLANK or SEARCH.
- `tof_valid`  out  1  one-cycle pulse when an echo is found.
- `tof_count`  out  CNT_W  index of the first sample of the qualifying run; holds until the next result.
- `timeout`  out  1  one-cycle pulse when the window expires without an echo.

## Operation
- States:
  - IDLE → BLANK on `burst_start`.
  - BLANK → SEARCH when `idx == BLANK`.
  - SEARCH → DONE on echo.
  - SEARCH → IDLE on timeout.
  - DONE → IDLE after one cycle.
- `burst_start` in any state:
  - restarts to BLANK;
  - clears `idx`, the run counter and the pipeline valid bit;
  - latches `threshold`;
  - aborts any search in progress with no output.
- `idx` counts accepted samples (`sample_valid` high, state BLANK or SEARCH). The first sample after `burst_start` is index 0.
- A `sample_valid` in the same cycle as `burst_start` is discarded.
- Samples arriving in IDLE or DONE are ignored.
- Energy: `sample_data` is sign-extended and squared into a 2*DATA_W unsigned value; this cannot overflow.
- Compare: `energy > thr_latched` (strictly greater).
- In SEARCH, each above-threshold sample increments `run`; a below-threshold sample clears it to 0.
- When `run` is 0 and the sample is above threshold, `run_start <= idx_of_sample`.
- When `run` reaches HOLD:
  - `tof_count <= run_start`;
  - `tof_valid` pulses;
  - state goes to DONE.
- Timeout: in SEARCH, an accepted sample with index MAX_SAMPLES−1 that does not complete a run pulses `timeout` and returns to IDLE.
- Runs never span the BLANK/SEARCH boundary; `run` is 0 on entry to SEARCH.
- `idx` saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset values: `busy=0`, `tof_valid=0`, `timeout=0`, `tof_count=0`; state IDLE; `idx`, `run` and thresholds all 0.
- Pipeline:
  - cycle t: sample accepted; `idx` is tagged.
  - t+1: energy registered.
  - t+2: compare/run update registered; `tof_valid`/`timeout` asserted.
  - Latency from `sample_valid` to `tof_valid` is 2 cycles.
- Throughput: one sample per cycle. Back-to-back `sample_valid` is legal.
- `busy` goes high the cycle after `burst_start` and falls in the same cycle `tof_valid`/`timeout` pulses.
- `tof_valid` and `timeout` are mutually exclusive.
- `tof_count` updates in the same cycle `tof_valid` rises.
- `RST` mid-search: outputs return to reset values the next cycle; the in-flight pipeline is dropped.

## Structure
- Package `tof_pkg`:
  - state enum (IDLE, BLANK, SEARCH, DONE);
  - default width constants DATA_W, CNT_W;
  - a localparam for energy width `2*DATA_W`.
- Sub-module `echo_energy_cmp`: registered squarer plus comparator. Passes through the valid bit and index tag, and is flushed by `burst_start`/`RST`.
- Top-level holds the FSM, `idx`/`run` counters and output registers.

## Test plan
- Reset, then `burst_start`, then 200 zero samples → `busy` stays 1, no `tof_valid`, no `timeout`. Continue to index 3799 → `timeout` pulses 2 cycles after sample 3799 and `busy` drops to 0.
- `threshold=100`, samples 0..99 = 0, samples 100–102 = ±20 (energy 400) → `tof_valid` 2 cycles after sample 102, `tof_count=100`.
- Same as above but ±20 at samples 10–12 (inside BLANK), zeros elsewhere → no detection; `timeout` at index 3799.
- Pattern 20, 20, 0, 20, 20, 20 starting at index 150 → `tof_count=153`. The broken run is discarded.
- Second `burst_start` at index 120 of an active search with ±20 at 110–111 → no output. The new sequence's indices restart at 0; a run at new 70–72 gives `tof_count=70`.
- Sample exactly at energy = threshold (10 with `threshold=100`) → not counted. Extreme sample −2^27 → energy 2^54, no overflow, counted as above threshold.

Source files
------------

// File: rtl/tof_echo_detector_pkg.sv
// Shared types and default widths for the time-of-flight echo detector.
package tof_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLANK  = 2'd1,
        S_SEARCH = 2'd2,
        S_DONE   = 2'd3
    } tof_state_e;

    localparam int DEF_DATA_W   = 28;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_ENERGY_W = 2 * DEF_DATA_W;

endpackage

// File: rtl/tof_echo_detector_energy_cmp.sv
// Registered squarer; the comparator works on the registered energy so the
// top can register the run update one cycle later.
module echo_energy_cmp
    import tof_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     CLK_FAST,
    input  logic                     RST,
    input  logic                     i_flush,
    input  logic                     i_vld,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic [CNT_W-1:0]         i_idx,
    input  logic                     i_srch,
    input  logic [2*DATA_W-1:0]      i_thr,
    output logic                     o_vld,
    output logic [CNT_W-1:0]         o_idx,
    output logic                     o_srch,
    output logic                     o_above
);

    localparam int EW = 2 * DATA_W;

    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] w_sq;
    logic                 r_vld;
    logic [EW-1:0]        r_energy;
    logic [CNT_W-1:0]     r_idx;
    logic                 r_srch;

    // Full-width square of a DATA_W value always fits in 2*DATA_W bits.
    assign w_ext = {{DATA_W{i_data[DATA_W-1]}}, i_data};
    assign w_sq  = w_ext * w_ext;

    always_ff @(posedge CLK_FAST) begin
        if (RST || i_flush) begin
            r_vld <= 1'b0;
        end else begin
            r_vld <= i_vld;
        end
    end

    always_ff @(posedge CLK_FAST) begin
        if (i_vld) begin
            r_energy <= w_sq;
            r_idx    <= i_idx;
            r_srch   <= i_srch;
        end
    end

    assign o_vld   = r_vld;
    assign o_idx   = r_idx;
    assign o_srch  = r_srch;
    assign o_above = (r_energy > i_thr);

endmodule

// File: rtl/tof_echo_detector.sv
// Echo detector: blanking, first HOLD-long above-threshold run search and
// timeout, fed by the band-pass FIR source stream.
module tof_echo_detector
    import tof_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int BLANK       = 64,
    parameter int HOLD        = 3,
    parameter int MAX_SAMPLES = 3800
) (
    input  logic                     CLK_FAST,
    input  logic                     RST,
    input  logic                     burst_start,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_data,
    input  logic [2*DATA_W-1:0]      threshold,
    output logic                     busy,
    output logic                     tof_valid,
    output logic [CNT_W-1:0]         tof_count,
    output logic                     timeout
);

    localparam int EW    = 2 * DATA_W;
    localparam int RUN_W = $clog2(HOLD + 1);

    tof_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_idx;
    logic [RUN_W-1:0] r_run;
    logic [CNT_W-1:0] r_run_start;
    logic [EW-1:0]    r_thr;
    logic             r_tof_valid;
    logic             r_timeout;
    logic [CNT_W-1:0] r_tof_count;

    logic             w_accept;
    logic             w_srch_tag;
    logic             w_cmp_vld;
    logic [CNT_W-1:0] w_cmp_idx;
    logic             w_cmp_srch;
    logic             w_cmp_above;
    logic             w_eval;
    logic             w_hit;
    logic             w_last;

    assign w_accept = sample_valid && !burst_start &&
                      (r_state == S_BLANK || r_state == S_SEARCH);
    // Tag by index, not state: the sample that arrives as idx reaches BLANK
    // still belongs to the search window.
    assign w_srch_tag = (r_idx >= CNT_W'(BLANK));

    echo_energy_cmp #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_energy_cmp (
        .CLK_FAST (CLK_FAST),
        .RST      (RST),
        .i_flush  (burst_start),
        .i_vld    (w_accept),
        .i_data   (sample_data),
        .i_idx    (r_idx),
        .i_srch   (w_srch_tag),
        .i_thr    (r_thr),
        .o_vld    (w_cmp_vld),
        .o_idx    (w_cmp_idx),
        .o_srch   (w_cmp_srch),
        .o_above  (w_cmp_above)
    );

    assign w_eval = w_cmp_vld && w_cmp_srch && (r_state == S_SEARCH);
    assign w_hit  = w_eval && w_cmp_above && (r_run == RUN_W'(HOLD - 1));
    assign w_last = w_eval && !w_hit && (w_cmp_idx == CNT_W'(MAX_SAMPLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = S_IDLE;
            S_BLANK:  if (r_idx >= CNT_W'(BLANK)) w_state_nxt = S_SEARCH;
            S_SEARCH: begin
                if (w_hit)       w_state_nxt = S_DONE;
                else if (w_last) w_state_nxt = S_IDLE;
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (burst_start) w_state_nxt = S_BLANK;
    end

    always_ff @(posedge CLK_FAST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK_FAST) begin
        if (RST) begin
            r_idx       <= '0;
            r_run       <= '0;
            r_run_start <= '0;
            r_thr       <= '0;
            r_tof_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_tof_count <= '0;
        end else if (burst_start) begin
            r_idx       <= '0;
            r_run       <= '0;
            r_thr       <= threshold;
            r_tof_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_tof_valid <= w_hit;
            r_timeout   <= w_last;
            if (w_accept && r_idx != '1) r_idx <= r_idx + 1'b1;
            if (w_eval) begin
                if (w_cmp_above) begin
                    r_run <= w_hit ? '0 : r_run + 1'b1;
                    if (r_run == '0) r_run_start <= w_cmp_idx;
                    // With HOLD==1 the run starts and ends on the same sample.
                    if (w_hit) r_tof_count <= (r_run == '0) ? w_cmp_idx : r_run_start;
                end else begin
                    r_run <= '0;
                end
            end
        end
    end

    assign busy      = (r_state == S_BLANK) || (r_state == S_SEARCH);
    assign tof_valid = r_tof_valid;
    assign timeout   = r_timeout;
    assign tof_count = r_tof_count;

endmodule

// File: tb/tb_tof_echo_detector.sv
// Directed and randomized bench; outputs are compared every cycle against a
// window-scan reference model of the echo rules.
module tb_tof_echo_detector;

    localparam int DW   = 28;
    localparam int CW   = 16;
    localparam int BLK  = 64;
    localparam int HLD  = 3;
    localparam int MAXS = 3800;
    localparam int EW   = 2 * DW;

    logic                 CLK_FAST = 1'b0;
    logic                 RST = 1'b1;
    logic                 burst_start = 1'b0;
    logic                 sample_valid = 1'b0;
    logic signed [DW-1:0] sample_data = '0;
    logic [EW-1:0]        threshold = '0;
    logic                 busy, tof_valid, timeout;
    logic [CW-1:0]        tof_count;

    int n_pass = 0, n_fail = 0, n_total = 0;

    // reference model state
    bit     m_active = 0;
    int     m_nidx = 0;
    bit     m_pend = 0;
    bit     m_pend_to = 0;
    int     m_pend_cnt = 0;
    longint m_thr = 0;
    bit     abv[MAXS];
    bit     exp_busy = 0, exp_tv = 0, exp_to = 0;
    int     exp_cnt = 0;

    tof_echo_detector #(
        .DATA_W(DW), .CNT_W(CW), .BLANK(BLK), .HOLD(HLD), .MAX_SAMPLES(MAXS)
    ) dut (
        .CLK_FAST     (CLK_FAST),
        .RST          (RST),
        .burst_start  (burst_start),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .threshold    (threshold),
        .busy         (busy),
        .tof_valid    (tof_valid),
        .tof_count    (tof_count),
        .timeout      (timeout)
    );

    always #7 CLK_FAST = ~CLK_FAST;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_above(input logic signed [DW-1:0] d);
        longint e;
        e = longint'(d) * longint'(d);
        return e > m_thr;
    endfunction

    // Model: a result is decided by the sample that closes the first window of
    // HLD above-threshold samples lying wholly at or after BLK, and becomes
    // visible one edge after that sample's own edge.
    task automatic model_edge(input bit r, input bit bs, input bit v, input logic signed [DW-1:0] d);
        int  k;
        bit  all;
        exp_tv = 0;
        exp_to = 0;
        if (r) begin
            m_active = 0; m_pend = 0; exp_busy = 0; exp_cnt = 0; m_thr = 0;
            return;
        end
        if (bs) begin
            m_active = 1; m_nidx = 0; m_pend = 0; exp_busy = 1;
            m_thr = longint'({8'b0, threshold});
            return;
        end
        if (m_pend) begin
            m_pend = 0;
            exp_busy = 0;
            if (m_pend_to) exp_to = 1;
            else begin exp_tv = 1; exp_cnt = m_pend_cnt; end
        end
        if (v && m_active) begin
            k = m_nidx;
            m_nidx++;
            abv[k] = is_above(d);
            all = 0;
            if (k >= BLK + HLD - 1) begin
                all = 1;
                for (int j = k - HLD + 1; j <= k; j++) all &= abv[j];
            end
            if (all) begin
                m_pend = 1; m_pend_to = 0; m_pend_cnt = k - HLD + 1; m_active = 0;
            end else if (k == MAXS - 1) begin
                m_pend = 1; m_pend_to = 1; m_active = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit bs, input bit v, input logic signed [DW-1:0] d);
        RST = r; burst_start = bs; sample_valid = v; sample_data = d;
        @(posedge CLK_FAST);
        model_edge(r, bs, v, d);
        @(negedge CLK_FAST);
        chk("busy",      64'(busy),      64'(exp_busy));
        chk("tof_valid", 64'(tof_valid), 64'(exp_tv));
        chk("timeout",   64'(timeout),   64'(exp_to));
        chk("tof_count", 64'(tof_count), 64'(exp_cnt));
    endtask

    task automatic burst(input logic [EW-1:0] t);
        threshold = t;
        step(0, 1, 0, '0);
    endtask

    task automatic send(input logic signed [DW-1:0] d);
        step(0, 0, 1, d);
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) send('0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0);
    endtask

    function automatic logic signed [DW-1:0] rnd_data();
        int t;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: t = int'($urandom_range(0, 16)) - 8;
            5, 6, 7:       t = int'($urandom_range(20, 40)) * ($urandom_range(0, 1) != 0 ? 1 : -1);
            8:             t = 0;
            default:       t = ($urandom_range(0, 1) != 0) ? -(2 ** (DW - 1)) : (2 ** (DW - 1)) - 1;
        endcase
        return DW'(t);
    endfunction

    function automatic logic [EW-1:0] rnd_thr();
        case ($urandom_range(0, 3))
            0:       return EW'(100);
            1:       return EW'($urandom_range(0, 2000));
            2:       return EW'(1) << (EW - 1);
            default: return '0;
        endcase
    endfunction

    initial begin
        // reset state
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        idle(2);

        // zeros for the whole window: timeout at index MAXS-1
        burst(EW'(100));
        zeros(200);
        chk("busy_after_200", 64'(busy), 64'(1));
        zeros(MAXS - 200);
        idle(3);

        // run at 100..102 just past blanking
        burst(EW'(100));
        zeros(100);
        send(28'sd20); send(-28'sd20); send(28'sd20);
        idle(4);
        chk("count_100", 64'(tof_count), 64'(100));

        // run inside blanking is masked
        burst(EW'(100));
        zeros(10);
        send(28'sd20); send(-28'sd20); send(28'sd20);
        zeros(MAXS - 13);
        idle(3);

        // broken run discarded
        burst(EW'(100));
        zeros(150);
        send(28'sd20); send(28'sd20); send('0);
        send(28'sd20); send(28'sd20); send(28'sd20);
        idle(4);
        chk("count_153", 64'(tof_count), 64'(153));

        // restart mid-search; sample coincident with burst_start discarded
        burst(EW'(100));
        zeros(110);
        send(28'sd20); send(-28'sd20);
        zeros(8);
        threshold = EW'(100);
        step(0, 1, 1, 28'sd20);
        zeros(70);
        send(28'sd20); send(28'sd20); send(-28'sd20);
        idle(4);
        chk("count_70", 64'(tof_count), 64'(70));

        // energy equal to threshold is not above; most-negative sample is
        burst(EW'(100));
        zeros(64);
        send(28'sd10); send(-28'sd10); send(28'sd10);
        send(-28'sd134217728); send(-28'sd134217728); send(-28'sd134217728);
        idle(4);
        chk("count_67", 64'(tof_count), 64'(67));

        // reset during an active search
        burst(EW'(0));
        zeros(80);
        send(28'sd20);
        step(1, 0, 1, 28'sd20);
        idle(4);

        // randomized bursts with gaps and occasional restarts
        for (int b = 0; b < 6; b++) begin
            burst(rnd_thr());
            for (int c = 0; c < 9000 && (m_active || m_pend); c++) begin
                if ($urandom_range(0, 2999) == 0) burst(rnd_thr());
                else step(0, 0, $urandom_range(0, 4) != 0, rnd_data());
            end
            idle(3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
